// File: rtl/dm_absctrl.sv
// dm_absctrl: abstract-command sequencer for the debug module.
// Runs Access Register transfers to the halted hart and tracks busy/cmderr.
module dm_absctrl #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CmdValid,
    input  logic        CmdWrite,
    input  logic        CmdTransfer,
    input  logic [15:0] CmdRegNo,
    input  logic        ClearErr,
    input  logic        HartHalted,
    input  logic        HartAck,
    output logic        HartReq,
    output logic        HartWe,
    output logic [4:0]  HartRegNo,
    output logic        Data0En,
    output logic        Busy,
    output logic [2:0]  CmdErr
);

    localparam int CW = $clog2(TIMEOUT);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] ERR_BUSY    = 3'd1;
    localparam logic [2:0] ERR_NOTSUP  = 3'd2;
    localparam logic [2:0] ERR_EXCEPT  = 3'd3;
    localparam logic [2:0] ERR_HALTRES = 3'd4;

    if (TIMEOUT < 2 || XLEN < 1) begin : g_bad_param
        $error("dm_absctrl: TIMEOUT must be >= 2 and XLEN >= 1");
    end

    logic [1:0]    state;
    logic [1:0]    state_n;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          err_set;
    logic [2:0]    err_code;
    logic          timeout;
    logic          gpr_ok;

    assign timeout = (cnt == CW'(TIMEOUT - 1));
    assign gpr_ok  = (CmdRegNo[15:5] == 11'h080);

    // The data0 flop captures read data in the very cycle the hart acks.
    assign Data0En = (state == XFER) && HartAck && !HartWe;

    // Next state, command acceptance and error detection.
    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        err_set  = 1'b0;
        err_code = 3'd0;
        case (state)
            IDLE: begin
                if (CmdValid && CmdErr == 3'd0) begin
                    if (!HartHalted) begin
                        err_set  = 1'b1;
                        err_code = ERR_HALTRES;
                    end else if (CmdTransfer) begin
                        if (!gpr_ok) begin
                            err_set  = 1'b1;
                            err_code = ERR_NOTSUP;
                        end else begin
                            accept  = 1'b1;
                            state_n = XFER;
                        end
                    end
                end
            end
            XFER: begin
                if (HartAck) begin
                    state_n = DONE;
                end else if (timeout) begin
                    state_n = DONE;
                    if (CmdErr == 3'd0) begin
                        err_set  = 1'b1;
                        err_code = ERR_EXCEPT;
                    end
                end
                if (!err_set && CmdValid && CmdErr == 3'd0) begin
                    err_set  = 1'b1;
                    err_code = ERR_BUSY;
                end
            end
            DONE: begin
                state_n = IDLE;
                if (CmdValid && CmdErr == 3'd0) begin
                    err_set  = 1'b1;
                    err_code = ERR_BUSY;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, registered handshake outputs, timeout counter and sticky cmderr.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            HartReq   <= 1'b0;
            HartWe    <= 1'b0;
            HartRegNo <= 5'd0;
            Busy      <= 1'b0;
            CmdErr    <= 3'd0;
        end else begin
            state   <= state_n;
            Busy    <= (state_n != IDLE);
            HartReq <= (state_n == XFER);
            if (accept) begin
                HartWe    <= CmdWrite;
                HartRegNo <= CmdRegNo[4:0];
                cnt       <= '0;
            end else if (state == XFER) begin
                cnt <= cnt + CW'(1);
            end
            if (err_set) begin
                CmdErr <= err_code;
            end else if (ClearErr) begin
                CmdErr <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_dm_absctrl.sv
// tb_dm_absctrl: directed table, corner sequences and random run
// against a transaction-level model of the abstract-command sequencer.
module tb_dm_absctrl;

    localparam int TO = 16;

    typedef struct {
        logic        rst, v, w, t;
        logic [15:0] regno;
        logic        clr, h, ack;
    } in_t;

    typedef struct {
        in_t         i;
        logic        req, we;
        logic [4:0]  idx;
        logic        d0, busy;
        logic [2:0]  err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        CmdValid, CmdWrite, CmdTransfer;
    logic [15:0] CmdRegNo;
    logic        ClearErr, HartHalted, HartAck;
    logic        HartReq, HartWe, Data0En, Busy;
    logic [4:0]  HartRegNo;
    logic [2:0]  CmdErr;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: one outstanding transfer plus a one-cycle tail
    bit       m_req, m_tail, m_we;
    int       m_age;
    bit [4:0] m_idx;
    bit [2:0] m_err;

    logic       o_req, o_we, o_d0, o_busy;
    logic [4:0] o_idx;
    logic [2:0] o_err;

    dm_absctrl #(.XLEN(64), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .CmdValid(CmdValid), .CmdWrite(CmdWrite),
        .CmdTransfer(CmdTransfer), .CmdRegNo(CmdRegNo),
        .ClearErr(ClearErr), .HartHalted(HartHalted),
        .HartAck(HartAck), .HartReq(HartReq), .HartWe(HartWe),
        .HartRegNo(HartRegNo), .Data0En(Data0En),
        .Busy(Busy), .CmdErr(CmdErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model_edge(input in_t i);
        bit [2:0] code;
        code = 3'd0;
        if (i.rst) begin
            m_req = 0; m_tail = 0; m_we = 0;
            m_age = 0; m_idx = 0; m_err = 0;
            return;
        end
        if (m_req) begin
            if (i.ack) begin
                m_req = 0; m_tail = 1;
            end else if (m_age == TO - 1) begin
                m_req = 0; m_tail = 1; code = 3'd3;
            end else begin
                m_age++;
            end
            if (code == 0 && i.v) code = 3'd1;
        end else if (m_tail) begin
            m_tail = 0;
            if (i.v) code = 3'd1;
        end else if (i.v && m_err == 0) begin
            if (!i.h) code = 3'd4;
            else if (i.t) begin
                if (i.regno >= 16'h1000 && i.regno <= 16'h101F) begin
                    m_req = 1; m_age = 0;
                    m_we = i.w; m_idx = i.regno[4:0];
                end else begin
                    code = 3'd2;
                end
            end
        end
        if (code != 0 && m_err == 0) m_err = code;
        else if (i.clr) m_err = 0;
    endtask

    task automatic step(input in_t i);
        reset = i.rst; CmdValid = i.v; CmdWrite = i.w;
        CmdTransfer = i.t; CmdRegNo = i.regno;
        ClearErr = i.clr; HartHalted = i.h; HartAck = i.ack;
        @(negedge clk);
        o_req = HartReq; o_we = HartWe; o_idx = HartRegNo;
        o_d0 = Data0En; o_busy = Busy; o_err = CmdErr;
        chk("m_HartReq", 32'(o_req), 32'(m_req));
        chk("m_Busy", 32'(o_busy), 32'(m_req || m_tail));
        chk("m_CmdErr", 32'(o_err), 32'(m_err));
        chk("m_Data0En", 32'(o_d0), 32'(m_req && i.ack && !m_we));
        if (m_req) begin
            chk("m_HartWe", 32'(o_we), 32'(m_we));
            chk("m_HartRegNo", 32'(o_idx), 32'(m_idx));
        end
        @(posedge clk);
        model_edge(i);
        #1;
    endtask

    function automatic in_t mi(input logic rst, v, w, t,
                               input logic [15:0] rg,
                               input logic clr, h, ack);
        in_t r;
        r.rst = rst; r.v = v; r.w = w; r.t = t;
        r.regno = rg; r.clr = clr; r.h = h; r.ack = ack;
        return r;
    endfunction

    function automatic vec_t mk(input in_t i, input logic req, we,
                                input logic [4:0] idx,
                                input logic d0, busy,
                                input logic [2:0] err);
        vec_t r;
        r.i = i; r.req = req; r.we = we; r.idx = idx;
        r.d0 = d0; r.busy = busy; r.err = err;
        return r;
    endfunction

    task automatic go(input logic v, w, t, input logic [15:0] rg,
                      input logic clr, h, ack);
        step(mi(1'b0, v, w, t, rg, clr, h, ack));
    endtask

    task automatic idle(input logic ack);
        go(0, 0, 0, 16'h0, 0, 1, ack);
    endtask

    vec_t tab[19];
    int nb, nd, pc, bad, e3c, b0c;

    initial begin
        step_init();

        // halted write, error codes from idle, boundary regnos, read
        tab[0]  = mk(mi(0,0,0,0,16'h0000,0,1,0), 0,0, 0,0,0,0);
        tab[1]  = mk(mi(0,1,1,1,16'h101F,0,1,0), 0,0, 0,0,0,0);
        tab[2]  = mk(mi(0,0,0,0,16'h0000,0,1,1), 1,1,31,0,1,0);
        tab[3]  = mk(mi(0,0,0,0,16'h0000,0,1,0), 0,1,31,0,1,0);
        tab[4]  = mk(mi(0,1,0,1,16'h1005,0,0,0), 0,1,31,0,0,0);
        tab[5]  = mk(mi(0,0,0,0,16'h0000,0,1,0), 0,1,31,0,0,4);
        tab[6]  = mk(mi(0,1,0,1,16'h1003,0,1,0), 0,1,31,0,0,4);
        tab[7]  = mk(mi(0,0,0,0,16'h0000,1,1,0), 0,1,31,0,0,4);
        tab[8]  = mk(mi(0,1,0,1,16'h0300,0,1,0), 0,1,31,0,0,0);
        tab[9]  = mk(mi(0,0,0,0,16'h0000,0,1,0), 0,1,31,0,0,2);
        tab[10] = mk(mi(0,0,0,0,16'h0000,1,1,0), 0,1,31,0,0,2);
        tab[11] = mk(mi(0,1,0,0,16'h0300,0,1,0), 0,1,31,0,0,0);
        tab[12] = mk(mi(0,1,0,1,16'h1020,0,1,0), 0,1,31,0,0,0);
        tab[13] = mk(mi(0,0,0,0,16'h0000,1,1,0), 0,1,31,0,0,2);
        tab[14] = mk(mi(0,1,0,1,16'h1000,0,1,0), 0,1,31,0,0,0);
        tab[15] = mk(mi(0,0,0,0,16'h0000,0,1,0), 1,0, 0,0,1,0);
        tab[16] = mk(mi(0,0,0,0,16'h0000,0,1,1), 1,0, 0,1,1,0);
        tab[17] = mk(mi(0,0,0,0,16'h0000,0,1,1), 0,0, 0,0,1,0);
        tab[18] = mk(mi(0,0,0,0,16'h0000,0,1,0), 0,0, 0,0,0,0);
        for (int k = 0; k < 19; k++) begin
            step(tab[k].i);
            chk($sformatf("t%0d_req", k), 32'(o_req), 32'(tab[k].req));
            chk($sformatf("t%0d_we", k), 32'(o_we), 32'(tab[k].we));
            chk($sformatf("t%0d_idx", k), 32'(o_idx), 32'(tab[k].idx));
            chk($sformatf("t%0d_d0", k), 32'(o_d0), 32'(tab[k].d0));
            chk($sformatf("t%0d_busy", k), 32'(o_busy), 32'(tab[k].busy));
            chk($sformatf("t%0d_err", k), 32'(o_err), 32'(tab[k].err));
        end

        // halted read of x10, ack three cycles after HartReq rises
        go(1, 0, 1, 16'h100A, 0, 1, 0);
        nb = 0; nd = 0; pc = 0; bad = 0;
        for (int c = 1; c <= 7; c++) begin
            go(0, 0, 0, 16'h0, 0, 1, c == 4);
            nb += int'(o_busy);
            if (o_d0) begin nd++; pc = c; end
            if (o_req && (o_idx != 5'd10 || o_we)) bad++;
        end
        chk("rd_busy_cycles", 32'(nb), 32'd5);
        chk("rd_d0_pulses", 32'(nd), 32'd1);
        chk("rd_d0_cycle", 32'(pc), 32'd4);
        chk("rd_req_fields", 32'(bad), 32'd0);
        chk("rd_err", 32'(CmdErr), 32'd0);

        // second command one cycle into XFER
        go(1, 0, 1, 16'h1005, 0, 1, 0);
        bad = 0;
        go(1, 1, 1, 16'h1007, 0, 1, 0);
        if (o_req && o_idx != 5'd5) bad++;
        for (int c = 2; c <= 5; c++) begin
            go(0, 0, 0, 16'h0, 0, 1, c == 2);
            if (o_req && o_idx != 5'd5) bad++;
        end
        chk("busy_err", 32'(CmdErr), 32'd1);
        chk("busy_orig_regno", 32'(bad), 32'd0);
        go(0, 0, 0, 16'h0, 1, 1, 0);
        go(1, 0, 1, 16'h1001, 1, 0, 0);
        idle(0);
        chk("set_beats_clear", 32'(CmdErr), 32'd4);
        go(0, 0, 0, 16'h0, 1, 1, 0);

        // timeout with no ack
        go(1, 0, 1, 16'h1001, 0, 1, 0);
        nb = 0; e3c = 0; b0c = 0;
        for (int c = 1; c <= 20; c++) begin
            idle(0);
            nb += int'(o_req);
            if (e3c == 0 && o_err == 3'd3) e3c = c;
            if (b0c == 0 && !o_busy) b0c = c;
        end
        chk("to_req_cycles", 32'(nb), 32'(TO));
        chk("to_err_cycle", 32'(e3c), 32'(TO + 1));
        chk("to_busy0_cycle", 32'(b0c), 32'(TO + 2));
        go(0, 0, 0, 16'h0, 1, 1, 0);

        // ack arrives in the last allowed cycle
        go(1, 0, 1, 16'h1002, 0, 1, 0);
        nd = 0;
        for (int c = 1; c <= 20; c++) begin
            idle(c == TO);
            nd += int'(o_d0);
        end
        chk("to_ack_d0", 32'(nd), 32'd1);
        chk("to_ack_err", 32'(CmdErr), 32'd0);

        // reset while HartReq is high
        go(1, 1, 1, 16'h1004, 0, 1, 0);
        idle(0);
        idle(0);
        step(mi(1, 0, 0, 0, 16'h0, 0, 1, 0));
        chk("rst_req_before", 32'(o_req), 32'd1);
        idle(0);
        chk("rst_req", 32'(o_req), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_we_idx", 32'({o_we, o_idx}), 32'd0);
        go(1, 0, 1, 16'h1006, 0, 1, 0);
        idle(1);
        idle(0);
        idle(0);
        chk("post_rst_err", 32'(CmdErr), 32'd0);
        chk("post_rst_busy", 32'(Busy), 32'd0);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            in_t r;
            r.rst = ($urandom_range(0, 63) == 0);
            r.v = ($urandom_range(0, 3) == 0);
            r.w = 1'($urandom);
            r.t = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: r.regno = 16'h1000 + 16'($urandom_range(0, 31));
                1: r.regno = 16'h1020;
                2: r.regno = 16'h0FFF;
                default: r.regno = 16'($urandom);
            endcase
            if ($urandom_range(0, 1) == 0)
                r.regno = 16'h1000 + 16'($urandom_range(0, 31));
            r.clr = ($urandom_range(0, 15) == 0);
            r.h = ($urandom_range(0, 7) != 0);
            r.ack = ($urandom_range(0, 5) == 0);
            step(r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    task automatic step_init();
        reset = 1; CmdValid = 0; CmdWrite = 0; CmdTransfer = 0;
        CmdRegNo = 16'h0; ClearErr = 0; HartHalted = 1; HartAck = 0;
        repeat (2) @(posedge clk);
        model_edge(mi(1, 0, 0, 0, 16'h0, 0, 1, 0));
        #1;
    endtask

endmodule

// File: doc/dm_absctrl.md
# dm_absctrl

Abstract-command sequencer for the debug module. Accepts Access Register commands decoded from the DMI `command` write and checks hart halt state and register legality. It runs a request/acknowledge transfer to the halted hart's GPR file and generates the load enable for the external data0 enable-flop. It also maintains the sticky `cmderr` field and the `busy` bit reported in `abstractcs`.

## Interface
- XLEN, 64: hart register width; HartRData and the data0 path are XLEN bits.
- TIMEOUT, 16: maximum XFER cycles without HartAck before the transfer is aborted; must be at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- CmdValid  in  1  one-cycle strobe: DMI wrote `command` with cmdtype=0.
- CmdWrite  in  1  command write bit: 1 = data0 to register, 0 = register to data0.
- CmdTransfer  in  1  command transfer bit.
- CmdRegNo  in  16  command regno field.
- ClearErr  in  1  one-cycle strobe: DMI wrote 1s to `abstractcs.cmderr`.
- HartHalted  in  1  hart is in debug mode.
- HartAck  in  1  hart completed the requested GPR access this cycle.
- HartReq  out  1  GPR access request to the hart.
- HartWe  out  1  access is a write.
- HartRegNo  out  5  GPR index.
- Data0En  out  1  enable for the data0 flop to capture HartRData.
- Busy  out  1  `abstractcs.busy`.
- CmdErr  out  3  `abstractcs.cmderr`.

## Operation
States are IDLE, XFER and DONE. Reset enters IDLE.

Reset values:
- HartReq=0, HartWe=0, HartRegNo=0, Data0En=0, Busy=0, CmdErr=0.
- Timeout counter=0.

IDLE, on CmdValid. Conditions are checked in priority order, and the first match applies:
- CmdErr≠0: command ignored, no state change.
- !HartHalted: CmdErr←4 (halt/resume), stay in IDLE.
- CmdTransfer=0: command completes with no action, stay in IDLE.
- CmdRegNo outside 0x1000–0x101F: CmdErr←2 (not supported), stay in IDLE.
- Otherwise: latch CmdWrite and CmdRegNo[4:0], clear the counter, go to XFER.

XFER:
- HartReq=1, HartWe=latched write bit, HartRegNo=latched index, all held stable.
- HartAck=1: go to DONE. If the access is a read, Data0En=1 in this same cycle (combinational from state, HartAck and !write).
- No ack and counter==TIMEOUT−1: CmdErr←3 (exception), go to DONE, Data0En stays 0.
- Otherwise the counter increments.
- If HartAck and timeout coincide, the ack wins: no error.

DONE:
- HartReq=0. Lasts exactly one cycle, then IDLE.
- Gives the hart one cycle to deassert HartAck.

CmdValid while in XFER or DONE:
- CmdErr←1 (busy) if CmdErr is 0.
- The new command is dropped and the running transfer continues unaffected.

ClearErr: CmdErr←0 at the next edge. If an error is set in the same cycle, the set wins.

CmdErr is sticky. It changes only on set from 0, on ClearErr, or on reset. A nonzero CmdErr is never overwritten by another code.

HartAck is ignored in IDLE and DONE.

Reset asserted in any state:
- Next edge goes to IDLE, all outputs return to their reset values.
- A pending hart request is abandoned; HartReq is low the cycle after reset.

## Timing
- Registered outputs: state, Busy, CmdErr, HartReq, HartWe, HartRegNo.
- Combinational output: Data0En only.
- Busy=1 exactly when the state is XFER or DONE.
- Cycle 0 CmdValid accepted → cycle 1 Busy=1 and HartReq=1 → ack in cycle k → cycle k+1 DONE (Busy=1, HartReq=0) → cycle k+2 Busy=0.
- Minimum command latency, with the ack in cycle 1: Busy high for 2 cycles.
- Error codes from IDLE are visible on CmdErr the cycle after CmdValid; Busy stays 0.
- Timeout: with no ack, HartReq is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT); CmdErr=3 from cycle TIMEOUT+1.
- Back-to-back commands: CmdValid is accepted in the first IDLE cycle after DONE.

## Test plan
- Halted read: CmdRegNo=0x100A, CmdWrite=0, ack 3 cycles after HartReq rises.
  - Expect HartRegNo=10 and HartWe=0 throughout.
  - Data0En pulses for exactly 1 cycle, coincident with the ack.
  - Busy high for 5 cycles, CmdErr=0.
- Halted write: CmdRegNo=0x101F, CmdWrite=1, ack in cycle 1.
  - Expect HartRegNo=31, HartWe=1, Data0En never asserted, Busy high for 2 cycles.
- Error codes from IDLE:
  - HartHalted=0 with any command → CmdErr=4, HartReq never rises.
  - After ClearErr, halted command with CmdRegNo=0x0300 → CmdErr=2.
  - A further valid command while CmdErr≠0 → ignored, no HartReq.
- Busy error: second CmdValid 1 cycle into XFER → CmdErr=1, the first transfer completes normally with its original regno.
  - ClearErr in the same cycle as a new error → CmdErr stays nonzero.
- Timeout with TIMEOUT=16 and no ack → HartReq high for 16 cycles, then CmdErr=3 and Busy=0 two cycles later.
  - Repeat with the ack in cycle 16 → no error, read data captured.
- Reset mid-XFER with HartReq high → next cycle all outputs 0 and state IDLE.
  - A new valid command then completes with CmdErr=0.
